// File: rtl/gps_sv_sched_if.sv
// gps_sv_sched_if: code-generator control/capture signals and the result valid/ready channel.
interface gps_sv_sched_if;
  logic [5:0]   sv_num;
  logic         startRound;
  logic [12:0]  ca_code;
  logic [127:0] l_code;
  logic         l_code_valid;
  logic         res_valid;
  logic         res_ready;
  logic [5:0]   res_sv;
  logic [12:0]  res_ca;
  logic [127:0] res_l;
  modport master (
    output sv_num, startRound, res_valid, res_sv, res_ca, res_l,
    input  ca_code, l_code, l_code_valid, res_ready
  );
  modport slave (
    input  sv_num, startRound, res_valid, res_sv, res_ca, res_l,
    output ca_code, l_code, l_code_valid, res_ready
  );
endinterface

// File: rtl/gps_sv_sched.sv
// gps_sv_sched: sweeps the enabled SVs through the code generator and hands each capture to a consumer.
// Define GPS_SCHED_TIMEOUT_EN to add the WAIT watchdog that skips SVs whose generator never answers.
module gps_sv_sched #(
  parameter int START_HOLD     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] sv_mask,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  gps_sv_sched_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES > START_HOLD ? TIMEOUT_CYCLES : START_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(START_HOLD - 1);
  typedef enum logic [2:0] {IDLE, SCAN, START, WAIT, OUT, DONE} state_t;
  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [31:0]    mask_q, mask_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           seen_q, seen_d, err_q, err_d;
  logic [5:0]     sv_q, sv_d, res_sv_q, res_sv_d;
  logic [12:0]    res_ca_q, res_ca_d;
  logic [127:0]   res_l_q, res_l_d;
  logic           last_idx;
  assign last_idx = idx_q == 5'd31;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    err_d    = err_q;
    sv_d     = sv_q;
    res_sv_d = res_sv_q;
    res_ca_d = res_ca_q;
    res_l_d  = res_l_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        mask_d  = sv_mask;
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = SCAN;
      end
      SCAN: if (mask_q[idx_q]) begin
        sv_d    = {1'b0, idx_q} + 6'd1;
        cnt_d   = '0;
        state_d = START;
      end else begin
        idx_d   = idx_q + 5'd1;
        state_d = last_idx ? DONE : SCAN;
      end
      START: begin
        cnt_d   = cnt_q == HOLD_LAST ? '0 : cnt_q + 1'b1;
        seen_d  = 1'b0;
        state_d = cnt_q == HOLD_LAST ? WAIT : START;
      end
      // A level that is already high belongs to the previous round; only a fresh rise counts.
      WAIT: if (seen_q && bus.l_code_valid) begin
        res_sv_d = sv_q;
        res_ca_d = bus.ca_code;
        res_l_d  = bus.l_code;
        state_d  = OUT;
      end else begin
        seen_d = seen_q | ~bus.l_code_valid;
        cnt_d  = cnt_q + 1'b1;
`ifdef GPS_SCHED_TIMEOUT_EN
        if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          idx_d   = idx_q + 5'd1;
          state_d = last_idx ? DONE : SCAN;
        end
`endif
      end
      OUT: if (bus.res_ready) begin
        idx_d   = idx_q + 5'd1;
        state_d = last_idx ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      err_q    <= 1'b0;
      sv_q     <= '0;
      res_sv_q <= '0;
      res_ca_q <= '0;
      res_l_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      sv_q     <= sv_d;
      res_sv_q <= res_sv_d;
      res_ca_q <= res_ca_d;
      res_l_q  <= res_l_d;
    end
  end
  assign bus.sv_num     = sv_q;
  assign bus.startRound = state_q == START;
  assign bus.res_valid  = state_q == OUT;
  assign bus.res_sv     = res_sv_q;
  assign bus.res_ca     = res_ca_q;
  assign bus.res_l      = res_l_q;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  assign err_timeout    = err_q;
endmodule

// File: tb/tb_gps_sv_sched.sv
// tb_gps_sv_sched: table, hand-written and randomized sweeps checked against a generator/scoreboard model.
module tb_gps_sv_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [31:0] sv_mask = '0;
  logic busy, done, err_timeout;
  int checks = 0, failures = 0;
  gps_sv_sched_if bus();
  gps_sv_sched #(.START_HOLD(4), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk_50(clk), .rst_n(rst_n), .start(start), .abort(abort), .sv_mask(sv_mask),
    .busy(busy), .done(done), .err_timeout(err_timeout), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] sv; logic [12:0] ca; logic [127:0] l; } res_t;
  typedef struct { logic [31:0] mask; int n; logic [5:0] first; logic [5:0] last; } vec_t;
  res_t gq[$];
  logic [5:0] svq[$], bq[$];
  int gen_cnt = 0, gen_delay = 3, n_res = 0, dones = 0, bursts = 0, burst_len = 0;
  int ncyc = 0, low_run = 0, last_gap = 0;
  bit gen_on = 1'b1, stuck = 1'b0, mon_on = 1'b1, sr_prev = 1'b0;
  logic [5:0] burst_sv = '0, first_sv = '0, last_sv = '0, skip_sv = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score a handshake that this edge completes, then run the generator and monitors.
  task automatic step();
    res_t e;
    if (bus.res_valid && bus.res_ready && !abort && rst_n) begin
      n_res++;
      if (n_res == 1) first_sv = bus.res_sv;
      last_sv = bus.res_sv;
      if (svq.size() == 0) chk("res_unexpected", 128'(bus.res_sv), 128'(0));
      else chk("res_sv", 128'(bus.res_sv), 128'(svq.pop_front()));
      if (gq.size() == 0) chk("res_no_gen", 128'(bus.res_sv), 128'(0));
      else begin
        e = gq.pop_front();
        chk("res_gen_sv", 128'(bus.res_sv), 128'(e.sv));
        chk("res_ca", 128'(bus.res_ca), 128'(e.ca));
        chk("res_l", bus.res_l, e.l);
      end
    end
    @(posedge clk);
    #1;
    if (bus.startRound) begin
      if (!stuck) bus.l_code_valid = 1'b0;
      gen_cnt = gen_delay;
    end else if (gen_cnt > 0) begin
      gen_cnt--;
      if (gen_cnt == 0 && gen_on && bus.sv_num != skip_sv) begin
        bus.ca_code = 13'($urandom);
        bus.l_code = {$urandom, $urandom, $urandom, $urandom};
        bus.l_code_valid = 1'b1;
        gq.push_back('{sv: bus.sv_num, ca: bus.ca_code, l: bus.l_code});
      end
    end
    if (bus.startRound && !sr_prev) begin
      bursts++;
      burst_len = 0;
      burst_sv = bus.sv_num;
      last_gap = low_run;
      if (bq.size() == 0) chk("burst_unexpected", 128'(bus.sv_num), 128'(0));
      else chk("burst_sv", 128'(bus.sv_num), 128'(bq.pop_front()));
    end
    if (bus.startRound) begin
      burst_len++;
      low_run = 0;
      chk("burst_sv_stable", 128'(bus.sv_num), 128'(burst_sv));
    end else begin
      low_run++;
      if (sr_prev && mon_on) chk("burst_len", 128'(burst_len), 128'(4));
    end
    sr_prev = bus.startRound;
    if (done) dones++;
  endtask

  task automatic prep(input logic [31:0] m);
    svq.delete(); bq.delete(); gq.delete();
    n_res = 0; dones = 0; bursts = 0; gen_cnt = 0;
    first_sv = '0; last_sv = '0;
    for (int i = 0; i < 32; i++) if (m[i]) begin
      svq.push_back(6'(i + 1));
      bq.push_back(6'(i + 1));
    end
  endtask

  task automatic wait_done(input string name);
    ncyc = 0;
    while (!done && ncyc < 500) begin step(); ncyc++; end
    chk(name, 128'(done), 128'(1));
    step();
  endtask

  task automatic sweep(input logic [31:0] m, input bit rnd);
    sv_mask = m; start = 1'b1; bus.res_ready = 1'b1;
    step();
    start = 1'b0; ncyc = 1;
    while (!done && ncyc < 4000) begin
      if (rnd) begin
        start = $urandom_range(0, 7) == 0;
        sv_mask = $urandom;
        bus.res_ready = $urandom_range(0, 1) == 1;
        gen_delay = $urandom_range(2, 6);
      end
      step(); ncyc++;
    end
    start = 1'b0;
    chk("sweep_done", 128'(done), 128'(1));
    step();
    chk("busy_after_done", 128'(busy), 128'(0));
    chk("done_count", 128'(dones), 128'(1));
    chk("all_results_seen", 128'(svq.size()), 128'(0));
    chk("all_bursts_seen", 128'(bq.size()), 128'(0));
  endtask

  initial begin
    vec_t tbl[5];
    res_t e;
    logic [31:0] m;
    tbl[0] = '{32'h0000_0005, 2, 6'd1, 6'd3};
    tbl[1] = '{32'h8000_0000, 1, 6'd32, 6'd32};
    tbl[2] = '{32'h0000_0001, 1, 6'd1, 6'd1};
    tbl[3] = '{32'hC000_0001, 3, 6'd1, 6'd32};
    tbl[4] = '{32'h0001_0100, 2, 6'd9, 6'd17};
    bus.ca_code = '0; bus.l_code = '0; bus.l_code_valid = 1'b0; bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sv_num", 128'(bus.sv_num), 128'(0));
    chk("rst_startRound", 128'(bus.startRound), 128'(0));
    chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
    chk("rst_res_sv", 128'(bus.res_sv), 128'(0));
    chk("rst_res_ca", 128'(bus.res_ca), 128'(0));
    chk("rst_res_l", bus.res_l, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err_timeout), 128'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      prep(tbl[i].mask);
      gen_delay = 2 + i;
      sweep(tbl[i].mask, 1'b0);
      chk("tbl_count", 128'(n_res), 128'(tbl[i].n));
      chk("tbl_bursts", 128'(bursts), 128'(tbl[i].n));
      chk("tbl_first", 128'(first_sv), 128'(tbl[i].first));
      chk("tbl_last", 128'(last_sv), 128'(tbl[i].last));
      chk("tbl_sv_num_held", 128'(bus.sv_num), 128'(tbl[i].last));
    end

    prep(32'h0);
    sweep(32'h0, 1'b0);
    chk("zero_mask_latency", 128'(ncyc), 128'(33));
    chk("zero_mask_bursts", 128'(bursts), 128'(0));

    prep(32'h1);
    gen_delay = 3; sv_mask = 32'h1; start = 1'b1; bus.res_ready = 1'b0;
    step();
    start = 1'b0; ncyc = 0;
    while (!bus.res_valid && ncyc < 100) begin step(); ncyc++; end
    chk("hold_reach_out", 128'(bus.res_valid), 128'(1));
    e = gq.size() != 0 ? gq[0] : '0;
    for (int i = 0; i < 20; i++) begin
      start = i == 5;
      step();
      chk("hold_valid", 128'(bus.res_valid), 128'(1));
      chk("hold_sv", 128'(bus.res_sv), 128'(1));
      chk("hold_ca", 128'(bus.res_ca), 128'(e.ca));
      chk("hold_l", bus.res_l, e.l);
    end
    start = 1'b0;
    chk("hold_no_rerun", 128'(bursts), 128'(1));
    bus.res_ready = 1'b1;
    step();
    chk("hold_accepted", 128'(bus.res_valid), 128'(0));
    wait_done("hold_done");
    chk("hold_count", 128'(n_res), 128'(1));

    prep(32'h1);
    gen_on = 1'b0; stuck = 1'b1; bus.l_code_valid = 1'b1;
    sv_mask = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("stuck_no_capture", 128'(bus.res_valid), 128'(0));
    chk("stuck_busy", 128'(busy), 128'(1));
    bus.l_code_valid = 1'b0;
    step();
    chk("stuck_low_no_capture", 128'(bus.res_valid), 128'(0));
    bus.ca_code = 13'h0ABC; bus.l_code = {4{32'hDEAD_BEEF}}; bus.l_code_valid = 1'b1;
    gq.push_back('{sv: 6'd1, ca: 13'h0ABC, l: {4{32'hDEAD_BEEF}}});
    step();
    chk("stuck_capture", 128'(bus.res_valid), 128'(1));
    chk("stuck_ca", 128'(bus.res_ca), 128'(13'h0ABC));
    wait_done("stuck_done");
    chk("stuck_count", 128'(n_res), 128'(1));
    gen_on = 1'b1; stuck = 1'b0;

    prep(32'h1);
    gen_on = 1'b0; sv_mask = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("abort_in_wait", 128'({busy, bus.startRound}), 128'(2'b10));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_startRound", 128'(bus.startRound), 128'(0));
    chk("abort_res_valid", 128'(bus.res_valid), 128'(0));
    repeat (3) step();
    chk("abort_no_done", 128'(dones), 128'(0));
    chk("abort_no_result", 128'(n_res), 128'(0));
    gen_on = 1'b1;

    prep(32'h1);
    bus.res_ready = 1'b0; sv_mask = 32'h1; start = 1'b1;
    step();
    start = 1'b0; ncyc = 0;
    while (!bus.res_valid && ncyc < 100) begin step(); ncyc++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_out_res_valid", 128'(bus.res_valid), 128'(0));
    chk("abort_out_busy", 128'(busy), 128'(0));

    prep(32'h1);
    bus.res_ready = 1'b1; sv_mask = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_mid_start_pre", 128'(bus.startRound), 128'(1));
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_startRound", 128'(bus.startRound), 128'(0));
    chk("rst_async_busy", 128'(busy), 128'(0));
    chk("rst_async_sv_num", 128'(bus.sv_num), 128'(0));
    chk("rst_async_res_valid", 128'(bus.res_valid), 128'(0));
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("rst_no_done", 128'(dones), 128'(0));
    mon_on = 1'b1;

    for (int k = 0; k < 6; k++) begin
      m = k[0] ? $urandom : ($urandom & $urandom);
      prep(m);
      sweep(m, 1'b1);
      chk("rand_count", 128'(n_res), 128'($countones(m)));
      chk("rand_bursts", 128'(bursts), 128'($countones(m)));
    end
    chk("rand_no_err", 128'(err_timeout), 128'(0));

`ifdef GPS_SCHED_TIMEOUT_EN
    skip_sv = 6'd1;
    prep(32'h3);
    void'(svq.pop_front());
    gen_delay = 3;
    sweep(32'h3, 1'b0);
    chk("to_err", 128'(err_timeout), 128'(1));
    chk("to_count", 128'(n_res), 128'(1));
    chk("to_sv2_delivered", 128'(last_sv), 128'(2));
    chk("to_gap", 128'(last_gap), 128'(17));
    skip_sv = 6'd0;
    prep(32'h0);
    sweep(32'h0, 1'b0);
    chk("to_err_cleared", 128'(err_timeout), 128'(0));
`else
    chk("err_tied_low", 128'(err_timeout), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
